// File: rtl/lsu.sv
// Load/store unit: issues one memory access at a time on a req/gnt + rvalid bus,
// aligns/extends load data into the register-file writeback port.
module lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_v_x,
   input  logic              mem_we_x,
   input  logic [1:0]        mem_size_x,
   input  logic              mem_sign_x,
   input  logic [ADDR_W-1:0] mem_addr_x,
   input  logic [31:0]       mem_wdata_x,
   input  logic [4:0]        mem_rd_x,
   output logic              busy_x,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_be,
   output logic [31:0]       dbus_wdata,
   input  logic              dbus_gnt,
   input  logic              dbus_rvalid,
   input  logic [31:0]       dbus_rdata,
   output logic              rdm_v,
   output logic [4:0]        rd,
   output logic [31:0]       rd_data_m,
   output logic              misalign_m,
   output logic [ADDR_W-1:0] misalign_addr
);

   // state | meaning
   // IDLE  | ready to accept mem_v_x
   // REQ   | dbus_req held until dbus_gnt
   // RESP  | load granted, waiting for dbus_rvalid
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rdm_v_q, rdm_v_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

   logic              bad_access;
   logic              load_done;
   logic [31:0]       shifted;
   logic [31:0]       load_data;

   always_comb begin
      bad_access = (mem_size_x == 2'd3)
                || (mem_size_x == 2'd1 && mem_addr_x[0])
                || (mem_size_x == 2'd2 && mem_addr_x[1:0] != 2'b00);
   end

   always_comb begin
      shifted = dbus_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    load_data = sign_q ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
         2'd1:    load_data = sign_q ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      we_d            = we_q;
      size_d          = size_q;
      sign_d          = sign_q;
      off_d           = off_q;
      rd_d            = rd_q;
      addr_d          = addr_q;
      be_d            = be_q;
      wdata_d         = wdata_q;
      rd_data_d       = rd_data_q;
      misalign_d      = 1'b0;
      misalign_addr_d = misalign_addr_q;
      load_done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_v_x) begin
               if (bad_access) begin
                  misalign_d      = 1'b1;
                  misalign_addr_d = mem_addr_x;
               end else begin
                  state_d = REQ;
                  we_d    = mem_we_x;
                  size_d  = mem_size_x;
                  sign_d  = mem_sign_x;
                  off_d   = mem_addr_x[1:0];
                  rd_d    = mem_rd_x;
                  addr_d  = {mem_addr_x[ADDR_W-1:2], 2'b00};
                  case (mem_size_x)
                     2'd0: begin
                        be_d    = 4'b0001 << mem_addr_x[1:0];
                        wdata_d = {4{mem_wdata_x[7:0]}};
                     end
                     2'd1: begin
                        be_d    = mem_addr_x[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{mem_wdata_x[15:0]}};
                     end
                     default: begin
                        be_d    = 4'b1111;
                        wdata_d = mem_wdata_x;
                     end
                  endcase
               end
            end
         end
         REQ: begin
            if (dbus_gnt) begin
               if (we_q) begin
                  state_d = IDLE;
               end else if (dbus_rvalid) begin
                  state_d   = IDLE;
                  load_done = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (dbus_rvalid) begin
               state_d   = IDLE;
               load_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_done) begin
         rd_data_d = load_data;
      end
      rdm_v_d = load_done && (rd_q != 5'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         we_q            <= 1'b0;
         size_q          <= 2'd0;
         sign_q          <= 1'b0;
         off_q           <= 2'd0;
         rd_q            <= 5'd0;
         addr_q          <= '0;
         be_q            <= 4'd0;
         wdata_q         <= 32'd0;
         rdm_v_q         <= 1'b0;
         rd_data_q       <= 32'd0;
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         we_q            <= we_d;
         size_q          <= size_d;
         sign_q          <= sign_d;
         off_q           <= off_d;
         rd_q            <= rd_d;
         addr_q          <= addr_d;
         be_q            <= be_d;
         wdata_q         <= wdata_d;
         rdm_v_q         <= rdm_v_d;
         rd_data_q       <= rd_data_d;
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   assign busy_x        = (state_q != IDLE);
   assign dbus_req      = (state_q == REQ);
   assign dbus_we       = we_q;
   assign dbus_addr     = addr_q;
   assign dbus_be       = be_q;
   assign dbus_wdata    = wdata_q;
   assign rdm_v         = rdm_v_q;
   assign rd            = rd_q;
   assign rd_data_m     = rd_data_q;
   assign misalign_m    = misalign_q;
   assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, misalign faults, wait states, reset abort.
module tb_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_v_x, mem_we_x, mem_sign_x;
   logic [1:0]  mem_size_x;
   logic [31:0] mem_addr_x, mem_wdata_x;
   logic [4:0]  mem_rd_x;
   logic        busy_x, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic        dbus_gnt, dbus_rvalid;
   logic        rdm_v, misalign_m;
   logic [4:0]  rd;
   logic [31:0] rd_data_m, misalign_addr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .mem_v_x(mem_v_x), .mem_we_x(mem_we_x), .mem_size_x(mem_size_x),
      .mem_sign_x(mem_sign_x), .mem_addr_x(mem_addr_x), .mem_wdata_x(mem_wdata_x),
      .mem_rd_x(mem_rd_x), .busy_x(busy_x),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .rdm_v(rdm_v), .rd(rd), .rd_data_m(rd_data_m),
      .misalign_m(misalign_m), .misalign_addr(misalign_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request for the cycle ending at the next posedge; returns at the following negedge.
   task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rdx);
      mem_v_x = 1'b1; mem_we_x = we; mem_size_x = size; mem_sign_x = sign;
      mem_addr_x = addr; mem_wdata_x = wdata; mem_rd_x = rdx;
      @(negedge clk);
      mem_v_x = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      mem_v_x = 0; mem_we_x = 0; mem_size_x = 0; mem_sign_x = 0;
      mem_addr_x = 0; mem_wdata_x = 0; mem_rd_x = 0;
      dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy_x, 0);
      chk("rst_req", dbus_req, 0);
      chk("rst_we", dbus_we, 0);
      chk("rst_rdm_v", rdm_v, 0);
      chk("rst_misalign", misalign_m, 0);
      chk("rst_addr", dbus_addr, 0);
      chk("rst_be", dbus_be, 0);
      chk("rst_rd_data", rd_data_m, 0);
      chk("rst_misalign_addr", misalign_addr, 0);
      reset = 1'b1;
      @(negedge clk);

      // word store, gnt after two wait cycles
      issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd1);
      chk("st_w_req1", dbus_req, 1);
      chk("st_w_busy", busy_x, 1);
      chk("st_w_we", dbus_we, 1);
      chk("st_w_addr", dbus_addr, 32'h100);
      chk("st_w_be", dbus_be, 4'hF);
      chk("st_w_wdata", dbus_wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("st_w_req2", dbus_req, 1);
      chk("st_w_rdm2", rdm_v, 0);
      @(negedge clk);
      chk("st_w_req3", dbus_req, 1);
      chk("st_w_addr3", dbus_addr, 32'h100);
      dbus_gnt = 1;
      @(negedge clk);
      dbus_gnt = 0;
      chk("st_w_req_off", dbus_req, 0);
      chk("st_w_busy_off", busy_x, 0);
      chk("st_w_rdm_off", rdm_v, 0);
      @(negedge clk);
      chk("st_w_rdm_after", rdm_v, 0);

      // byte load sign-extend, gnt+rvalid same cycle, then back-to-back zero-extend
      issue(0, 2'd0, 1, 32'h203, 32'h0, 5'd5);
      chk("ld_b_req", dbus_req, 1);
      chk("ld_b_be", dbus_be, 4'b1000);
      chk("ld_b_addr", dbus_addr, 32'h200);
      chk("ld_b_we", dbus_we, 0);
      dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 32'h80112233;
      @(negedge clk);
      dbus_gnt = 0; dbus_rvalid = 0;
      chk("ld_bs_rdm_v", rdm_v, 1);
      chk("ld_bs_rd", rd, 5);
      chk("ld_bs_data", rd_data_m, 32'hFFFFFF80);
      chk("ld_bs_busy", busy_x, 0);
      issue(0, 2'd0, 0, 32'h203, 32'h0, 5'd5);
      chk("ld_bz_rdm_pulse", rdm_v, 0);
      chk("ld_bz_req", dbus_req, 1);
      dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 32'h80112233;
      @(negedge clk);
      dbus_gnt = 0; dbus_rvalid = 0;
      chk("ld_bz_rdm_v", rdm_v, 1);
      chk("ld_bz_data", rd_data_m, 32'h00000080);

      // half store and half load at offset 2
      issue(1, 2'd1, 0, 32'h12, 32'h0000ABCD, 5'd0);
      chk("st_h_addr", dbus_addr, 32'h10);
      chk("st_h_be", dbus_be, 4'b1100);
      chk("st_h_wdata", dbus_wdata, 32'hABCDABCD);
      dbus_gnt = 1;
      @(negedge clk);
      dbus_gnt = 0;
      chk("st_h_busy_off", busy_x, 0);
      issue(0, 2'd1, 1, 32'h12, 32'h0, 5'd7);
      chk("ld_h_be", dbus_be, 4'b1100);
      dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 32'h80010000;
      @(negedge clk);
      dbus_gnt = 0; dbus_rvalid = 0;
      chk("ld_h_rdm_v", rdm_v, 1);
      chk("ld_h_rd", rd, 7);
      chk("ld_h_data", rd_data_m, 32'hFFFF8001);

      // misaligned word and illegal size
      issue(0, 2'd2, 0, 32'h102, 32'h0, 5'd4);
      chk("mis_w_pulse", misalign_m, 1);
      chk("mis_w_addr", misalign_addr, 32'h102);
      chk("mis_w_req", dbus_req, 0);
      chk("mis_w_busy", busy_x, 0);
      @(negedge clk);
      chk("mis_w_pulse_end", misalign_m, 0);
      chk("mis_w_addr_hold", misalign_addr, 32'h102);
      issue(0, 2'd3, 0, 32'h100, 32'h0, 5'd4);
      chk("mis_s3_pulse", misalign_m, 1);
      chk("mis_s3_addr", misalign_addr, 32'h100);
      chk("mis_s3_busy", busy_x, 0);
      @(negedge clk);
      chk("mis_s3_pulse_end", misalign_m, 0);

      // stray rvalid before gnt, then long response wait
      issue(0, 2'd2, 0, 32'h40, 32'h0, 5'd9);
      dbus_rvalid = 1; dbus_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      dbus_rvalid = 0;
      chk("stray_req", dbus_req, 1);
      chk("stray_rdm", rdm_v, 0);
      dbus_gnt = 1;
      @(negedge clk);
      dbus_gnt = 0;
      chk("resp_req_off", dbus_req, 0);
      for (int i = 0; i < 3; i++) begin
         chk("resp_busy", busy_x, 1);
         @(negedge clk);
      end
      chk("resp_busy4", busy_x, 1);
      dbus_rvalid = 1; dbus_rdata = 32'h12345678;
      @(negedge clk);
      dbus_rvalid = 0;
      chk("resp_rdm_v", rdm_v, 1);
      chk("resp_rd", rd, 9);
      chk("resp_data", rd_data_m, 32'h12345678);
      chk("resp_busy_off", busy_x, 0);

      // rd=0 load: no writeback pulse, data still updated
      issue(0, 2'd2, 0, 32'h44, 32'h0, 5'd0);
      dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      dbus_gnt = 0; dbus_rvalid = 0;
      chk("rd0_rdm_v", rdm_v, 0);
      chk("rd0_data", rd_data_m, 32'hCAFEF00D);
      chk("rd0_busy", busy_x, 0);

      // reset while waiting in RESP
      issue(0, 2'd2, 0, 32'h80, 32'h0, 5'd6);
      dbus_gnt = 1;
      @(negedge clk);
      dbus_gnt = 0;
      chk("rstm_busy_pre", busy_x, 1);
      reset = 1'b0;
      #1;
      chk("rstm_busy", busy_x, 0);
      chk("rstm_req", dbus_req, 0);
      @(negedge clk);
      reset = 1'b1;
      dbus_rvalid = 1; dbus_rdata = 32'h55555555;
      @(negedge clk);
      dbus_rvalid = 0;
      chk("rstm_late_rvalid", rdm_v, 0);
      chk("rstm_late_busy", busy_x, 0);
      issue(0, 2'd0, 0, 32'h1, 32'h0, 5'd3);
      chk("rstm_next_be", dbus_be, 4'b0010);
      dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 32'h0000AB00;
      @(negedge clk);
      dbus_gnt = 0; dbus_rvalid = 0;
      chk("rstm_next_rdm_v", rdm_v, 1);
      chk("rstm_next_rd", rd, 3);
      chk("rstm_next_data", rd_data_m, 32'h000000AB);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
